// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer for a word-organised data memory. Sub-word stores use read-modify-write.
// Define LSU_MISALIGN_EN to allow misaligned and word-crossing accesses; without it they complete with err.
module lsu_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wrt,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_WR0,
    S_WR1,
    S_DONE
  } state_t;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] sz);
    case (sz)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  state_t        state_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          st_q;
  logic          cross_q;
  logic [31:0]   lo_q, hi_q;
  logic [31:0]   lo_d, hi_d;
  logic [31:0]   rdata_q;
  logic          busy_q, done_q, err_q;
  logic [31:0]   mem_addr_q;
  logic          mem_rd_q, mem_wrt_q;
  logic [31:0]   mem_wdata_q;

  // Decode of the request presented on the inputs (only meaningful in IDLE)
  logic [1:0]  in_off;
  logic [2:0]  in_sz;
  logic        in_f3_ok, in_mis, in_cross, in_err, in_sw_aligned;
  logic [31:0] in_w0_ext;
  logic        unused_addr_hi;

  assign in_off    = addr[1:0];
  assign in_sz     = size_of(funct3);
  assign in_f3_ok  = req_wr ? (funct3 inside {3'b000, 3'b001, 3'b010})
                            : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_EN
  assign in_mis    = 1'b0;
`else
  assign in_mis    = ((in_sz == 3'd2) && in_off[0]) || ((in_sz == 3'd4) && (in_off != 2'b00));
`endif
  assign in_cross      = (({1'b0, in_off} + in_sz) > 3'd4);
  assign in_err        = (req_rd & req_wr) | ~in_f3_ok | in_mis;
  assign in_sw_aligned = req_wr & (funct3 == 3'b010) & (in_off == 2'b00);
  assign in_w0_ext     = {{(32-AW){1'b0}}, addr[AW+1:2]};
  assign unused_addr_hi = ^addr[31:AW+2];

  // Decode of the latched access
  logic [1:0]    off_q;
  logic [2:0]    sz_q;
  logic [AW-1:0] w0, w1;
  logic [31:0]   w0_ext, w1_ext;

  assign off_q  = addr_q[1:0];
  assign sz_q   = size_of(f3_q);
  assign w0     = addr_q[AW+1:2];
  assign w1     = (w0 == AW'(DEPTH - 1)) ? '0 : w0 + 1'b1;
  assign w0_ext = {{(32-AW){1'b0}}, w0};
  assign w1_ext = {{(32-AW){1'b0}}, w1};

  // lo/hi as they will be after this edge, so the merge and load paths see fresh read data
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (state_q == S_RD0) lo_d = mem_rdata;
    if (state_q == S_RD1) hi_d = mem_rdata;
  end

  logic [63:0] old64, ins64, new64;
  logic [7:0]  be;

  assign old64 = {hi_d, lo_d};
  assign ins64 = {32'd0, wdata_q} << {off_q, 3'b000};
  assign be    = {4'b0000, lane_mask(sz_q)} << off_q;

  // Byte-lane merge over the two-word window; lanes 4..7 belong to hi
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign new64[8*gi +: 8] = be[gi] ? ins64[8*gi +: 8] : old64[8*gi +: 8];
    end
  endgenerate

  logic [31:0] ld_bytes, ld_val;

  assign ld_bytes = 32'(old64 >> {off_q, 3'b000});

  always_comb begin
    ld_val = 32'd0;
    case (f3_q)
      3'b000:  ld_val = {{24{ld_bytes[7]}}, ld_bytes[7:0]};
      3'b001:  ld_val = {{16{ld_bytes[15]}}, ld_bytes[15:0]};
      3'b010:  ld_val = ld_bytes;
      3'b100:  ld_val = {24'd0, ld_bytes[7:0]};
      3'b101:  ld_val = {16'd0, ld_bytes[15:0]};
      default: ld_val = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      f3_q        <= 3'd0;
      st_q        <= 1'b0;
      cross_q     <= 1'b0;
      lo_q        <= 32'd0;
      hi_q        <= 32'd0;
      rdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_rd_q    <= 1'b0;
      mem_wrt_q   <= 1'b0;
      mem_wdata_q <= 32'd0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wrt_q <= 1'b0;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      case (state_q)
        S_IDLE: begin
          if (req_rd | req_wr) begin
            addr_q     <= addr[AW+1:0];
            wdata_q    <= wdata;
            f3_q       <= funct3;
            st_q       <= req_wr;
            cross_q    <= in_cross;
            busy_q     <= 1'b1;
            mem_addr_q <= in_w0_ext;
            if (in_err) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else if (in_sw_aligned) begin
              state_q     <= S_WR0;
              mem_wrt_q   <= 1'b1;
              mem_wdata_q <= wdata;
            end else begin
              state_q  <= S_RD0;
              mem_rd_q <= 1'b1;
            end
          end
        end
        S_RD0: begin
          if (cross_q) begin
            state_q    <= S_RD1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= w1_ext;
          end else if (st_q) begin
            state_q     <= S_WR0;
            mem_wrt_q   <= 1'b1;
            mem_wdata_q <= new64[31:0];
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            rdata_q <= ld_val;
          end
        end
        S_RD1: begin
          mem_addr_q <= w0_ext;
          if (st_q) begin
            state_q     <= S_WR0;
            mem_wrt_q   <= 1'b1;
            mem_wdata_q <= new64[31:0];
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            rdata_q <= ld_val;
          end
        end
        S_WR0: begin
          if (cross_q) begin
            state_q     <= S_WR1;
            mem_wrt_q   <= 1'b1;
            mem_addr_q  <= w1_ext;
            mem_wdata_q <= new64[63:32];
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_WR1: begin
          state_q    <= S_DONE;
          done_q     <= 1'b1;
          mem_addr_q <= w0_ext;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  // Reset must suppress a write even when it lands in the middle of WR0/WR1
  assign mem_wrt   = mem_wrt_q & ~RST;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expectations queued at drive time, popped and checked on done.
// Covers both builds; the misaligned cases branch on LSU_MISALIGN_EN.
module tb_lsu_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_rd, req_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wrt;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  lsu_ctrl #(.DEPTH(32), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .req_rd(req_rd), .req_wr(req_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem      [0:31];
  logic [31:0] init_mem [0:31];
  logic [31:0] exp_mem  [0:31];
  logic        preload;

  assign mem_rdata = mem[mem_addr[4:0]];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else if (mem_wrt) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          chk_rd;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic mem_check(input int idx);
    check($sformatf("mem%0d", idx), mem[idx], exp_mem[idx]);
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rdata,
                        input bit chk_rd, input logic exp_err, input int exp_lat,
                        input int exp_nrd, input int exp_nwr, input bit pulse_busy);
    exp_t        e;
    exp_t        r;
    int          cyc;
    int          n_rd;
    int          n_wr;
    bit          got_done;
    logic [31:0] got_rdata;
    logic        got_err;
    e.tag = tag; e.rdata = exp_rdata; e.chk_rd = chk_rd; e.err = exp_err;
    e.lat = exp_lat; e.nrd = exp_nrd; e.nwr = exp_nwr;
    sb_q.push_back(e);
    req_rd = rd; req_wr = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge CLK);
    req_rd = 1'b0; req_wr = 1'b0;
    cyc = 1; n_rd = 0; n_wr = 0; got_done = 1'b0; got_rdata = 32'd0; got_err = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!got_done && cyc <= 20) begin
      n_rd += int'(mem_rd);
      n_wr += int'(mem_wrt);
      if (done) begin
        got_done  = 1'b1;
        got_rdata = rdata;
        got_err   = err;
      end else begin
        if (cyc == 1 && pulse_busy) begin
          req_wr = 1'b1; funct3 = 3'b010; addr = 32'h0000_001C; wdata = 32'hFFFF_FFFF;
        end
        @(negedge CLK);
        req_wr = 1'b0;
        cyc++;
      end
    end
    r = sb_q.pop_front();
    check({r.tag, "_done"}, 32'(got_done), 32'd1);
    if (got_done) begin
      check({r.tag, "_lat"}, cyc, r.lat);
      check({r.tag, "_err"}, 32'(got_err), 32'(r.err));
      if (r.chk_rd) check({r.tag, "_rdata"}, got_rdata, r.rdata);
    end
    check({r.tag, "_nrd"}, n_rd, r.nrd);
    check({r.tag, "_nwr"}, n_wr, r.nwr);
    @(negedge CLK);
    check({r.tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({r.tag, "_idle_done"}, 32'(done), 32'd0);
    $display("op %s: lat=%0d err=%0b rdata=%h rd=%0d wr=%0d", r.tag, cyc, got_err, got_rdata, n_rd, n_wr);
  endtask

  initial begin
    RST = 1'b1; preload = 1'b1;
    req_rd = 1'b0; req_wr = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 32; i++) init_mem[i] = 32'h1000_0000 + i;
    init_mem[3]  = 32'h8899_AABB;
    init_mem[4]  = 32'h1122_3344;
    init_mem[5]  = 32'h5566_7788;
    init_mem[31] = 32'hCAFE_F00D;
    init_mem[0]  = 32'h0BAD_C0DE;
    for (int i = 0; i < 32; i++) exp_mem[i] = init_mem[i];
    repeat (2) @(negedge CLK);
    preload = 1'b0;
    @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wrt", 32'(mem_wrt), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    RST = 1'b0;

    //     tag        rd wr f3      addr   wdata          exp_rdata   chk err lat nrd nwr pulse
    run_op("lb_0d",   1, 0, 3'b000, 32'h0D, 32'h0,         32'hFFFF_FFAA, 1, 0, 2, 1, 0, 0);
    run_op("lbu_0d",  1, 0, 3'b100, 32'h0D, 32'h0,         32'h0000_00AA, 1, 0, 2, 1, 0, 0);
    run_op("lh_0e",   1, 0, 3'b001, 32'h0E, 32'h0,         32'hFFFF_8899, 1, 0, 2, 1, 0, 0);
    run_op("lhu_0c",  1, 0, 3'b101, 32'h0C, 32'h0,         32'h0000_AABB, 1, 0, 2, 1, 0, 0);
    run_op("lw_10",   1, 0, 3'b010, 32'h10, 32'h0,         32'h1122_3344, 1, 0, 2, 1, 0, 1);
    mem_check(7);
    run_op("lb_13",   1, 0, 3'b000, 32'h13, 32'h0,         32'h0000_0011, 1, 0, 2, 1, 0, 0);
    run_op("sh_0e",   0, 1, 3'b001, 32'h0E, 32'h0000_1234, 32'h0,         0, 0, 3, 1, 1, 0);
    exp_mem[3] = 32'h1234_AABB; mem_check(3);
    run_op("sb_0f",   0, 1, 3'b000, 32'h0F, 32'hFFFF_FF5A, 32'h0,         0, 0, 3, 1, 1, 0);
    exp_mem[3] = 32'h5A34_AABB; mem_check(3);
    run_op("sw_18",   0, 1, 3'b010, 32'h18, 32'hDEAD_BEEF, 32'h0,         0, 0, 2, 0, 1, 0);
    exp_mem[6] = 32'hDEAD_BEEF; mem_check(6);
    run_op("lw_18",   1, 0, 3'b010, 32'h18, 32'h0,         32'hDEAD_BEEF, 1, 0, 2, 1, 0, 0);
    run_op("lhu_0e",  1, 0, 3'b101, 32'h0E, 32'h0,         32'h0000_5A34, 1, 0, 2, 1, 0, 0);
`ifdef LSU_MISALIGN_EN
    run_op("lw_13",   1, 0, 3'b010, 32'h13, 32'h0,         32'h6677_8811, 1, 0, 3, 2, 0, 0);
    run_op("sw_7e",   0, 1, 3'b010, 32'h7E, 32'hDEAD_BEEF, 32'h0,         0, 0, 5, 2, 2, 0);
    exp_mem[31] = 32'hBEEF_F00D; exp_mem[0] = 32'h0BAD_DEAD;
`else
    run_op("lw_13",   1, 0, 3'b010, 32'h13, 32'h0,         32'h0,         1, 1, 1, 0, 0, 0);
    run_op("sw_7e",   0, 1, 3'b010, 32'h7E, 32'hDEAD_BEEF, 32'h0,         0, 1, 1, 0, 0, 0);
`endif
    mem_check(31); mem_check(0);
    run_op("lw_0c_a", 1, 0, 3'b010, 32'h0C, 32'h0,         32'h5A34_AABB, 1, 0, 2, 1, 0, 0);
    run_op("rd_wr",   1, 1, 3'b010, 32'h10, 32'h0000_0000, 32'h0,         1, 1, 1, 0, 0, 0);
    run_op("ld_f011", 1, 0, 3'b011, 32'h10, 32'h0,         32'h0,         1, 1, 1, 0, 0, 0);
    run_op("st_f100", 0, 1, 3'b100, 32'h10, 32'h0000_00FF, 32'h0,         0, 1, 1, 0, 0, 0);
    mem_check(4);
`ifdef LSU_MISALIGN_EN
    run_op("lh_0d",   1, 0, 3'b001, 32'h0D, 32'h0,         32'h0000_34AA, 1, 0, 2, 1, 0, 0);
    run_op("sh_13",   0, 1, 3'b001, 32'h13, 32'h0000_CDEF, 32'h0,         0, 0, 5, 2, 2, 0);
    exp_mem[4] = 32'hEF22_3344; exp_mem[5] = 32'h5566_77CD;
`else
    run_op("lh_0d",   1, 0, 3'b001, 32'h0D, 32'h0,         32'h0,         1, 1, 1, 0, 0, 0);
    run_op("sh_13",   0, 1, 3'b001, 32'h13, 32'h0000_CDEF, 32'h0,         0, 1, 1, 0, 0, 0);
`endif
    mem_check(4); mem_check(5);

    // Reset landing in WR0 of a byte store
    req_wr = 1'b1; funct3 = 3'b000; addr = 32'h20; wdata = 32'h0000_0077;
    @(negedge CLK);
    req_wr = 1'b0;
    @(negedge CLK);
    check("rst_wr0_reached", 32'(mem_wrt), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_wr_gated", 32'(mem_wrt), 32'd0);
    @(negedge CLK);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    check("rstmid_mem_rd", 32'(mem_rd), 32'd0);
    check("rstmid_mem_addr", mem_addr, 32'd0);
    check("rstmid_mem_wdata", mem_wdata, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("rstmid_no_done", 32'(done), 32'd0);
    mem_check(8);
    $display("op rst_mid_sb: mem8=%h", mem[8]);
    run_op("lw_0c_b", 1, 0, 3'b010, 32'h0C, 32'h0,         32'h5A34_AABB, 1, 0, 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the core's execute stage (ALU byte address, register-file store data) and the word-organised data memory. Converts RV32I byte/halfword/word loads and stores into word-index memory cycles, with read-modify-write for sub-word stores and sign or zero extension for loads. Multi-cycle; the core stalls on `busy`.

## Interface
Parameters:
- `DEPTH`, 32: data memory depth in 32-bit words; power of two.
- `AW`, 5: word-index width, log2(`DEPTH`).

Ports. Clocking and reset are fixed: one clock; reset is synchronous and active-high.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req_rd` in 1: load request.
- `req_wr` in 1: store request.
- `funct3` in 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `rdata` out 32: extended load result.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: error flag; valid only when `done`=1.
- `mem_addr` out 32: word index to data memory.
- `mem_rd` out 1: read strobe.
- `mem_wrt` out 1: write strobe.
- `mem_wdata` out 32: write word.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
- Request accept: a request is taken only in IDLE. `addr`, `wdata`, `funct3` and type are latched on the accept edge. Requests while `busy`=1 are ignored.
- Byte offset `off` = `addr[1:0]`. Access size `sz` = 1, 2 or 4 bytes.
- Word index `w0` = `addr[AW+1:2]`, zero-extended to 32 bits. `w1` = (`w0`+1) mod `DEPTH`, so the index wraps from `DEPTH`-1 to 0.
- Crossing access: `off`+`sz` > 4. Only crossing accesses touch `w1`.
- States: IDLE, RD0, RD1, WR0, WR1, DONE.
- Transitions:
  - IDLE→RD0 on a load or a sub-word store.
  - IDLE→WR0 on an aligned SW.
  - IDLE→DONE on an error.
  - RD0→RD1 if the access crosses; otherwise RD0→DONE for a load, RD0→WR0 for a store.
  - RD1→DONE for a load, RD1→WR0 for a store.
  - WR0→WR1 if the access crosses, else WR0→DONE.
  - WR1→DONE.
  - DONE→IDLE.
- RD0/RD1: `mem_addr`=`w0`/`w1`, `mem_rd`=1. `mem_rdata` is captured into `lo`/`hi` on the rising edge that ends the state.
- WR0/WR1: `mem_wrt`=1. `mem_wdata` is `lo`/`hi` with the store bytes merged at byte lanes `off..off+sz-1` (little-endian); lanes past byte 3 go to `hi`. An aligned SW writes `wdata` directly.
- Load assembly: bytes are taken from {`hi`,`lo`} >> (8·`off`), then extended by the width code. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- `rdata` updates in DONE and holds until the next DONE.
- Errors: `err`=1 with `done`, no memory strobe issued, `rdata`=0. Error causes:
  - `req_rd` and `req_wr` both high.
  - Undefined `funct3`.
  - Misalignment, when `LSU_MISALIGN_EN` is undefined.
- Outside RD/WR states, `mem_rd`=`mem_wrt`=0 and `mem_addr`=`w0`.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_rd`=0, `mem_wrt`=0, `mem_addr`=0, `mem_wdata`=0, `lo`=`hi`=0.
- `mem_wrt` is gated by `!RST`, so no memory write occurs in a reset cycle even mid-WR.
- Reset mid-operation: abandon the access, return to IDLE, no `done` pulse.
- Latency, from the accept edge to the `done` cycle:
  - Aligned LW, LB, LH: 2.
  - SW: 2.
  - Aligned SB/SH: 3.
  - Crossing load: 3.
  - Crossing store: 5.
  - Error: 1.
- `busy` is high from the cycle after accept through DONE.
- The earliest back-to-back accept is the cycle after DONE.

## Configuration
- `LSU_MISALIGN_EN` defined: accesses with `off` not a multiple of `sz` are legal. Non-crossing ones complete in one word; crossing ones use the split RD1/WR1 path.
- `LSU_MISALIGN_EN` undefined: any access with `off` % `sz` ≠ 0 is an error. RD1/WR1 are unreachable and may be optimised away.

## Test plan
- Memory word 3 = 0x8899AABB. LB at `addr` 0x0D → `rdata`=0xFFFFFFAA, `done` 2 cycles after accept. LBU at 0x0D → 0x000000AA.
- Word 3 = 0x8899AABB. SH `wdata`=0x1234 at 0x0E → word 3 = 0x1234AABB. Exactly one `mem_wrt` cycle, latency 3.
- Word 4 = 0x11223344, word 5 = 0x55667788. LW at 0x13:
  - With `LSU_MISALIGN_EN`: `rdata`=0x66778811, latency 3.
  - Without: `err`=1, `rdata`=0, no `mem_rd`.
- With `LSU_MISALIGN_EN`: SW 0xDEADBEEF at 0x7E (word 31, `off` 2) → word 31 upper half = 0xBEEF, word 0 lower half = 0xDEAD. Other bytes unchanged; latency 5.
- `req_rd`=`req_wr`=1, and separately `funct3`=011 on a load → `err`=1 after 1 cycle, no memory strobe. A request pulsed while `busy` is ignored.
- Assert `RST` during WR0 of a SB → no memory change, `busy`=0 and all outputs at reset values next cycle, no `done`.
